// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer
//   Feeds operand pairs from a small FIFO into a sequential 8x8 multiplier,
//   waits out its fixed latency, and returns each 16-bit product over a
//   valid/ready result stream. Pairs with a zero operand skip the multiplier.
//   Exactly one product is in flight at a time, so results leave in push order.

module mul_operand_sequencer #(
   parameter int DEPTH   = 4,   // operand FIFO entries, power of 2, >= 2
   parameter int MUL_LAT = 5    // cycles from mul_st until mul_answer is final, >= 1
) (
   input  logic                    clk,
   input  logic                    rst,
   // operand stream
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [7:0]              in_a,
   input  logic [7:0]              in_b,
   // multiplier interface
   output logic                    mul_st,
   output logic [7:0]              mul_a,
   output logic [7:0]              mul_b,
   input  logic [15:0]             mul_answer,
   // result stream
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [15:0]             out_result,
   // status
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic                    busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LAT_W = $clog2(MUL_LAT) + 1;

   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
   localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MUL_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t state;
   state_t state_next;

   // ------------------------------------------------------------------
   // Operand FIFO
   // ------------------------------------------------------------------
   logic [15:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [15:0]      head;
   logic [7:0]       head_a;
   logic [7:0]       head_b;
   logic             push;
   logic             pop;

   // Readiness looks only at the occupancy, never at a same-cycle pop, so a
   // full FIFO refuses a push even in the cycle it is being drained.
   assign in_ready = (fifo_count < FULL_COUNT);
   assign push     = in_valid && in_ready;

   assign head   = mem[rd_ptr];
   assign head_a = head[15:8];
   assign head_b = head[7:0];

   // Storage write: one entry per accepted operand pair.
   // NOTE: the storage array carries no reset; an entry is only read after
   // the write pointer has passed it, so clearing it would cost flops for nothing.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_a, in_b};
      end
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
   // NOTE: every register here uses <= so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Sequencing FSM
   // ------------------------------------------------------------------
   logic [LAT_W-1:0] lat_cnt;
   logic             load_zero;     // zero operand: result known without multiplying
   logic             start_lat;     // START cycle: arm the latency counter
   logic             capture;       // last WAIT cycle: mul_answer is final
   logic             release_out;   // result handshake completed

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and per-cycle control strobes.
   // NOTE: every output of this block gets a default first so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next  = state;
      pop         = 1'b0;
      load_zero   = 1'b0;
      start_lat   = 1'b0;
      capture     = 1'b0;
      release_out = 1'b0;
      case (state)
         S_IDLE: begin
            if (fifo_count != '0) begin
               pop = 1'b1;
               if ((head_a == 8'd0) || (head_b == 8'd0)) begin
                  load_zero  = 1'b1;
                  state_next = S_HOLD;
               end else begin
                  state_next = S_START;
               end
            end
         end
         S_START: begin
            start_lat  = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (lat_cnt == '0) begin
               capture    = 1'b1;
               state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               release_out = 1'b1;
               state_next  = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // The start pulse is gated by reset so it can never reach the multiplier
   // in a cycle where the multiplier itself is being reset.
   assign mul_st = (state == S_START) && !rst;
   assign busy   = (state != S_IDLE);

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------

   // Operand holding registers: loaded only on a pop, so they stay stable
   // through START and WAIT while the multiplier works on them.
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_a <= 8'd0;
         mul_b <= 8'd0;
      end else if (pop) begin
         mul_a <= head_a;
         mul_b <= head_b;
      end
   end

   // Latency counter: armed in START, counts down through WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_cnt <= '0;
      end else if (start_lat) begin
         lat_cnt <= LAT_LOAD;
      end else if ((state == S_WAIT) && (lat_cnt != '0)) begin
         lat_cnt <= lat_cnt - 1'b1;
      end
   end

   // Result register: mul_answer is sampled only on the final WAIT cycle,
   // so its intermediate values never reach the output.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_result <= 16'd0;
         out_valid  <= 1'b0;
      end else if (load_zero) begin
         out_result <= 16'd0;
         out_valid  <= 1'b1;
      end else if (capture) begin
         out_result <= mul_answer;
         out_valid  <= 1'b1;
      end else if (release_out) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// tb_mul_operand_sequencer
//   Directed bench for mul_operand_sequencer with a behavioural multiplier
//   whose answer is wrong until MUL_LAT cycles after the start pulse.

module tb_mul_operand_sequencer;

   localparam int DEPTH   = 4;
   localparam int MUL_LAT = 5;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [7:0]              in_a;
   logic [7:0]              in_b;
   logic                    mul_st;
   logic [7:0]              mul_a;
   logic [7:0]              mul_b;
   logic [15:0]             mul_answer;
   logic                    out_valid;
   logic                    out_ready;
   logic [15:0]             out_result;
   logic [$clog2(DEPTH):0]  fifo_count;
   logic                    busy;

   int checks = 0;
   int errors = 0;

   mul_operand_sequencer #(
      .DEPTH   (DEPTH),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .mul_st     (mul_st),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_answer (mul_answer),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Multiplier model: product is final from the MUL_LAT-th cycle after st.
   logic [15:0] m_prod;
   int          m_age;
   always @(posedge clk) begin
      if (rst) begin
         m_prod <= 16'd0;
         m_age  <= 0;
      end else if (mul_st) begin
         m_prod <= 16'(mul_a) * 16'(mul_b);
         m_age  <= 1;
      end else if (m_age < 100) begin
         m_age  <= m_age + 1;
      end
   end
   assign mul_answer = (m_age >= MUL_LAT) ? m_prod : (~m_prod ^ 16'(m_age));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Result collector, start-pulse counter and operand stability monitor.
   logic [15:0] got_q[$];
   int          st_count = 0;
   logic        prev_busy = 1'b0;
   logic [7:0]  prev_a = 8'd0;
   logic [7:0]  prev_b = 8'd0;
   always @(negedge clk) begin
      if (mul_st) st_count++;
      if (out_valid && out_ready) got_q.push_back(out_result);
      if (busy && prev_busy) begin
         check("hold_mul_a", mul_a, prev_a);
         check("hold_mul_b", mul_b, prev_b);
      end
      prev_busy = busy;
      prev_a    = mul_a;
      prev_b    = mul_b;
   end

   task automatic wait_results(input int n, input int budget, input string tag);
      int k = 0;
      while ((got_q.size() < n) && (k < budget)) begin
         tick();
         k++;
      end
      check(tag, got_q.size(), n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         base;
      int         st_base;
      logic [7:0] a3 [6];
      logic [7:0] b3 [6];
      logic       acc3 [6];
      logic [15:0] exp3 [5];
      logic [15:0] exp_q[$];
      int         pushed;
      int         guard;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = 8'd0;
      in_b      = 8'd0;
      out_ready = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_out_valid",  out_valid,  0);
      check("rst_out_result", out_result, 0);
      check("rst_busy",       busy,       0);
      check("rst_count",      fifo_count, 0);
      check("rst_mul_st",     mul_st,     0);
      check("rst_mul_a",      mul_a,      0);
      check("rst_mul_b",      mul_b,      0);
      check("rst_in_ready",   in_ready,   1);
      rst = 1'b0;

      // T1: single product, exact latency, held until handshake
      st_base  = st_count;
      in_valid = 1'b1; in_a = 8'd200; in_b = 8'd150;
      tick(); in_valid = 1'b0;                          // t+1
      check("t1_count_after_push", fifo_count, 1);
      check("t1_idle_before_pop",  busy,       0);
      tick();                                           // t+2
      check("t1_st",        mul_st,     1);
      check("t1_mul_a",     mul_a,      200);
      check("t1_mul_b",     mul_b,      150);
      check("t1_busy",      busy,       1);
      check("t1_count_pop", fifo_count, 0);
      tick();                                           // t+3
      check("t1_st_single", mul_st, 0);
      repeat (4) tick();                                // t+7
      check("t1_not_early", out_valid, 0);
      tick();                                           // t+8
      check("t1_valid",  out_valid,  1);
      check("t1_result", out_result, 16'h7530);
      tick();                                           // t+9
      check("t1_hold_valid",  out_valid,  1);
      check("t1_hold_result", out_result, 16'h7530);
      out_ready = 1'b1;
      tick();                                           // t+10
      out_ready = 1'b0;
      check("t1_released",  out_valid,          0);
      check("t1_idle",      busy,               0);
      check("t1_one_st",    st_count - st_base, 1);
      check("t1_one_out",   got_q.size(),       1);
      check("t1_out_value", got_q[0],           30000);

      // T2: two products back to back, in order, once each
      base = got_q.size();
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255;
      tick(); in_a = 8'd1; in_b = 8'd1;
      tick(); in_valid = 1'b0;
      wait_results(base + 2, 60, "t2_timeout");
      check("t2_first",  got_q[base],     16'hFE01);
      check("t2_second", got_q[base + 1], 1);
      repeat (10) tick();
      check("t2_no_dup", got_q.size(), base + 2);

      // T3: backpressure fills the FIFO; full FIFO refuses further pushes
      a3   = '{8'd2, 8'd10, 8'd100, 8'd17, 8'd128, 8'd9};
      b3   = '{8'd3, 8'd20, 8'd100, 8'd19, 8'd2,   8'd9};
      acc3 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp3 = '{16'd6, 16'd200, 16'd10000, 16'd323, 16'd256};
      out_ready = 1'b0;
      base = got_q.size();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_a = a3[i]; in_b = b3[i];
         check($sformatf("t3_ready%0d", i), in_ready, acc3[i]);
         tick();
      end
      check("t3_full_count", fifo_count, 4);
      check("t3_not_ready",  in_ready,   0);
      repeat (10) tick();
      check("t3_still_full",  fifo_count, 4);
      check("t3_refused",     in_ready,   0);
      check("t3_held_valid",  out_valid,  1);
      check("t3_held_result", out_result, 6);
      check("t3_none_out",    got_q.size(), base);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_results(base + 5, 120, "t3_timeout");
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3_result%0d", i), got_q[base + i], exp3[i]);
      end
      repeat (12) tick();
      check("t3_refused_not_emitted", got_q.size(), base + 5);

      // T4: zero-operand bypass, two cycles after push, no start pulse
      base    = got_q.size();
      st_base = st_count;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 8'd0; in_b = 8'd77;
      tick(); in_valid = 1'b0;                          // t+1
      check("t4a_not_yet", out_valid, 0);
      tick();                                           // t+2
      check("t4a_valid",  out_valid,  1);
      check("t4a_result", out_result, 0);
      tick();
      check("t4a_released", out_valid, 0);
      in_valid = 1'b1; in_a = 8'd77; in_b = 8'd0;
      tick(); in_valid = 1'b0;
      check("t4b_not_yet", out_valid, 0);
      tick();
      check("t4b_valid",  out_valid,  1);
      check("t4b_result", out_result, 0);
      tick();
      check("t4_no_st",    st_count - st_base, 0);
      check("t4_count",    got_q.size(),       base + 2);
      check("t4_first",    got_q[base],        0);
      check("t4_second",   got_q[base + 1],    0);

      // T5: reset in the middle of WAIT aborts the product
      base = got_q.size();
      in_valid = 1'b1; in_a = 8'd13; in_b = 8'd11;
      tick(); in_valid = 1'b0;                          // t+1 pop
      tick();                                           // t+2 START
      check("t5_st", mul_st, 1);
      tick();                                           // t+3 WAIT
      tick();                                           // t+4 WAIT
      rst = 1'b1;
      tick();                                           // t+5
      check("t5_rst_out_valid",  out_valid,  0);
      check("t5_rst_out_result", out_result, 0);
      check("t5_rst_busy",       busy,       0);
      check("t5_rst_count",      fifo_count, 0);
      check("t5_rst_mul_a",      mul_a,      0);
      check("t5_rst_mul_b",      mul_b,      0);
      check("t5_rst_mul_st",     mul_st,     0);
      rst = 1'b0;
      repeat (12) tick();
      check("t5_aborted", got_q.size(), base);
      in_valid = 1'b1; in_a = 8'd3; in_b = 8'd5;
      tick(); in_valid = 1'b0;
      wait_results(base + 1, 40, "t5_timeout");
      check("t5_after_reset", got_q[base], 15);
      // reset asserted during START suppresses the start pulse
      base = got_q.size();
      in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7;
      tick(); in_valid = 1'b0;
      tick();
      check("t5_start_reached", busy, 1);
      rst = 1'b1;
      #1;
      check("t5_st_gated", mul_st, 0);
      tick();
      rst = 1'b0;
      check("t5_start_abort_idle", busy, 0);
      repeat (12) tick();
      check("t5_start_abort_no_out", got_q.size(), base);

      // T6: random traffic against a scoreboard
      base   = got_q.size();
      pushed = 0;
      guard  = 0;
      while ((pushed < 500) && (guard < 20000)) begin
         in_valid  = ($urandom_range(3) != 0);
         in_a      = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
         in_b      = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
         out_ready = ($urandom_range(2) != 0);
         if (in_valid && in_ready) begin
            exp_q.push_back(16'(in_a) * 16'(in_b));
            pushed++;
         end
         tick();
         guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("t6_all_pushed", pushed, 500);
      wait_results(base + exp_q.size(), 200, "t6_timeout");
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("t6_result%0d", i), got_q[base + i], exp_q[i]);
      end
      repeat (10) tick();
      check("t6_no_extra", got_q.size(), base + exp_q.size());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
